// File: rtl/calc_entry_pkg.sv
// Calculator key-entry shared definitions.
// Key codes, operation codes and entry states.
package calc_entry_pkg;

  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_MUL = 5'd12;
  localparam logic [4:0] KEY_DIV = 5'd13;
  localparam logic [4:0] KEY_POW = 5'd14;
  localparam logic [4:0] KEY_EQ  = 5'd15;
  localparam logic [4:0] KEY_CLR = 5'd16;
  localparam logic [4:0] KEY_NEG = 5'd17;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

  typedef enum logic [1:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_CALC,
    S_SHOW
  } state_t;

  function automatic logic [2:0] key_op(input logic [4:0] k);
    return 3'(k - KEY_ADD);
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Sign/magnitude decimal operand accumulator.
// Counts digits and refuses new ones once full.
module calc_digit_acc #(
  parameter int NB = 64,
  parameter int MAX_DIGITS = 12,
  parameter int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [NB-1:0] load_val,
  input  logic [CW-1:0] load_cnt,
  input  logic          dig,
  input  logic [3:0]    d,
  input  logic          neg,
  output logic [NB-1:0] value,
  output logic          full,
  output logic          empty
);

  localparam logic [NB-1:0] TEN = NB'(10);

  logic          sgn;
  logic [NB-1:0] mag;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= 1'b0;
      mag <= '0;
      cnt <= '0;
    end else if (clr) begin
      sgn <= 1'b0;
      mag <= '0;
      cnt <= '0;
    end else if (load) begin
      sgn <= load_val[NB-1];
      mag <= load_val[NB-1] ? -load_val : load_val;
      cnt <= load_cnt;
    end else if (dig && !full) begin
      mag <= mag * TEN + NB'(d);
      cnt <= cnt + CW'(1);
    end else if (neg) begin
      sgn <= ~sgn;
    end
  end

  assign value = sgn ? -mag : mag;
  assign full  = (cnt == CW'(MAX_DIGITS));
  assign empty = (cnt == '0);

endmodule

// File: rtl/calc_entry.sv
// Keypad entry front end for an external calculator.
// Builds operands a/b, issues calc_req, latches the result.
import calc_entry_pkg::*;

module calc_entry #(
  parameter int NB = 64,
  parameter int MAX_DIGITS = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  input  logic [4:0]    key_code,
  output logic          key_ready,
  output logic [NB-1:0] a,
  output logic [NB-1:0] b,
  output logic [2:0]    operand,
  output logic          calc_req,
  input  logic [NB-1:0] result,
  output logic [NB-1:0] disp_value,
  output logic          done,
  output logic          digit_ovf
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t        state;
  logic [NB-1:0] disp_r;
  logic          take, k_dig, k_op, k_eq, k_clr, k_neg;
  logic          in_a, in_b, in_show;
  logic          a_full, a_empty, b_full, b_empty;
  logic          a_clr, a_load, a_dig, a_neg;
  logic          b_clr, b_dig, b_neg, ovf;
  logic [NB-1:0] a_ld_val;
  logic [CW-1:0] a_ld_cnt;

  assign key_ready = (state != S_CALC);
  assign take  = key_valid & key_ready;
  assign k_dig = take && (key_code <= 5'd9);
  assign k_op  = take && (key_code >= KEY_ADD) && (key_code <= KEY_POW);
  assign k_eq  = take && (key_code == KEY_EQ);
  assign k_clr = take && (key_code == KEY_CLR);
  assign k_neg = take && (key_code == KEY_NEG);
  assign in_a    = (state == S_ENTER_A);
  assign in_b    = (state == S_ENTER_B);
  assign in_show = (state == S_SHOW);

  // SHOW reloads a: a fresh digit, or the result for chaining/negation
  always_comb begin
    a_clr    = k_clr;
    a_dig    = k_dig & in_a;
    a_neg    = k_neg & in_a;
    a_load   = (k_dig | k_op | k_neg) & in_show;
    a_ld_val = disp_r;
    a_ld_cnt = CW'(MAX_DIGITS);
    if (k_dig) begin
      a_ld_val = NB'(key_code[3:0]);
      a_ld_cnt = CW'(1);
    end else if (k_neg) begin
      a_ld_val = -disp_r;
    end
    b_clr = k_clr | (k_op & in_a) | ((k_dig | k_op) & in_show);
    b_dig = k_dig & in_b;
    b_neg = k_neg & in_b;
    ovf   = (a_dig & a_full) | (b_dig & b_full);
  end

  calc_digit_acc #(.NB(NB), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_acc_a (
    .clk(clk), .rst_n(rst_n),
    .clr(a_clr), .load(a_load),
    .load_val(a_ld_val), .load_cnt(a_ld_cnt),
    .dig(a_dig), .d(key_code[3:0]), .neg(a_neg),
    .value(a), .full(a_full), .empty(a_empty)
  );

  calc_digit_acc #(.NB(NB), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_acc_b (
    .clk(clk), .rst_n(rst_n),
    .clr(b_clr), .load(1'b0),
    .load_val('0), .load_cnt('0),
    .dig(b_dig), .d(key_code[3:0]), .neg(b_neg),
    .value(b), .full(b_full), .empty(b_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ENTER_A;
      operand   <= OP_ADD;
      disp_r    <= '0;
      calc_req  <= 1'b0;
      done      <= 1'b0;
      digit_ovf <= 1'b0;
    end else begin
      calc_req  <= 1'b0;
      done      <= 1'b0;
      digit_ovf <= ovf;
      if (state == S_CALC) begin
        disp_r <= result;
        state  <= S_SHOW;
        done   <= 1'b1;
      end else begin
        unique case (1'b1)
          k_clr: begin
            state   <= S_ENTER_A;
            operand <= OP_ADD;
            disp_r  <= '0;
          end
          k_op && (in_a || in_show): begin
            operand <= key_op(key_code);
            state   <= S_ENTER_B;
          end
          k_op && in_b && b_empty: begin
            operand <= key_op(key_code);
          end
          (k_dig || k_neg) && in_show: begin
            state <= S_ENTER_A;
          end
          k_eq && in_b && !b_empty: begin
            state    <= S_CALC;
            calc_req <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    unique case (state)
      S_ENTER_A: disp_value = a;
      S_SHOW:    disp_value = disp_r;
      default:   disp_value = b;
    endcase
  end

  // a_empty is only informative for a; entry rules key off b
  logic unused_ok;
  assign unused_ok = a_empty;

endmodule

// File: tb/tb_calc_entry.sv
// Self-checking bench for calc_entry: directed keypad
// sequences plus random keys against a behavioural model.
module tb_calc_entry;

  localparam int MAXD = 12;
  localparam int MA = 0, MB = 1, MC = 2, MS = 3;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [63:0] a, b, result, disp_value;
  logic [2:0]  operand;
  logic        calc_req, done, digit_ovf;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int     m_mode;
  bit     a_s, b_s;
  longint a_m, b_m;
  int     a_c, b_c;
  int     m_op;
  longint m_disp;
  bit     m_req, m_done, m_ovf;

  calc_entry dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready),
    .a(a), .b(b), .operand(operand),
    .calc_req(calc_req), .result(result),
    .disp_value(disp_value), .done(done),
    .digit_ovf(digit_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint ipow(input longint x, input longint e);
    longint r;
    r = 1;
    if (e < 0) return 0;
    for (int i = 0; i < 63; i++) begin
      if (e[i]) r = r * x;
      x = x * x;
    end
    return r;
  endfunction

  // external calculator
  function automatic longint calc(input longint x, input longint y,
                                  input logic [2:0] op);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: begin
        if (y == 0) return 0;
        if (y == -1) return -x;
        return x / y;
      end
      3'd4: return ipow(x, y);
      default: return 0;
    endcase
  endfunction

  always_comb result = calc($signed(a), $signed(b), operand);

  function automatic longint sv(input bit s, input longint m);
    return s ? -m : m;
  endfunction

  task automatic model_reset();
    m_mode = MA;
    a_s = 0; a_m = 0; a_c = 0;
    b_s = 0; b_m = 0; b_c = 0;
    m_op = 0; m_disp = 0;
    m_req = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic load_a(input longint v);
    a_s = (v < 0);
    a_m = (v < 0) ? -v : v;
    a_c = MAXD;
  endtask

  task automatic model_step();
    int k;
    m_req = 0; m_done = 0; m_ovf = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == MC) begin
      m_disp = calc(sv(a_s, a_m), sv(b_s, b_m), 3'(m_op));
      m_mode = MS;
      m_done = 1;
      return;
    end
    if (!key_valid) return;
    k = int'(key_code);
    if (k == 16) begin
      model_reset();
      return;
    end
    if (m_mode == MA) begin
      if (k <= 9) begin
        if (a_c < MAXD) begin a_m = a_m * 10 + k; a_c++; end
        else m_ovf = 1;
      end else if (k == 17) a_s = !a_s;
      else if (k >= 10 && k <= 14) begin
        m_op = k - 10;
        b_s = 0; b_m = 0; b_c = 0;
        m_mode = MB;
      end
    end else if (m_mode == MB) begin
      if (k <= 9) begin
        if (b_c < MAXD) begin b_m = b_m * 10 + k; b_c++; end
        else m_ovf = 1;
      end else if (k == 17) b_s = !b_s;
      else if (k >= 10 && k <= 14) begin
        if (b_c == 0) m_op = k - 10;
      end else if (k == 15 && b_c > 0) begin
        m_mode = MC;
        m_req = 1;
      end
    end else begin
      if (k <= 9) begin
        a_s = 0; a_m = k; a_c = 1;
        b_s = 0; b_m = 0; b_c = 0;
        m_mode = MA;
      end else if (k >= 10 && k <= 14) begin
        load_a(m_disp);
        b_s = 0; b_m = 0; b_c = 0;
        m_op = k - 10;
        m_mode = MB;
      end else if (k == 17) begin
        load_a(-m_disp);
        m_mode = MA;
      end
    end
  endtask

  task automatic check(input string nm,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 5'(k);
    tick();
    key_valid = 1'b0;
  endtask

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      longint ed;
      ed = (m_mode == MA) ? sv(a_s, a_m) :
           (m_mode == MS) ? m_disp : sv(b_s, b_m);
      check("key_ready", 64'(key_ready), 64'(m_mode != MC));
      check("a", a, sv(a_s, a_m));
      check("b", b, sv(b_s, b_m));
      check("operand", 64'(operand), 64'(m_op));
      check("calc_req", 64'(calc_req), 64'(m_req));
      check("done", 64'(done), 64'(m_done));
      check("digit_ovf", 64'(digit_ovf), 64'(m_ovf));
      check("disp_value", disp_value, ed);
    end
  end

  initial begin
    int novf;
    int rr;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    model_reset();
    tick();
    tick();
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_disp", disp_value, 0);
    check("rst_op", 64'(operand), 0);
    check("rst_ready", 64'(key_ready), 1);
    check("rst_pulses", 64'({calc_req, done, digit_ovf}), 0);
    rst_n = 1'b1;
    tick();

    // 12 + 34
    press(1); press(2); press(10); press(3); press(4); press(15);
    check("d1_req", 64'(calc_req), 1);
    check("d1_a", a, 12);
    check("d1_b", b, 34);
    check("d1_op", 64'(operand), 0);
    tick();
    check("d1_disp", disp_value, 46);
    check("d1_done", 64'(done), 1);

    // chain: 46 - 6
    press(11); press(6); press(15);
    check("d2_a", a, 46);
    check("d2_b", b, 6);
    check("d2_op", 64'(operand), 1);
    tick();
    check("d2_disp", disp_value, 40);

    // -7 * 5
    press(16); press(7); press(17); press(12); press(5); press(15);
    check("d3_a", a, -7);
    check("d3_b", b, 5);
    check("d3_op", 64'(operand), 2);
    tick();
    check("d3_disp", disp_value, -35);

    // thirteen nines
    press(16);
    novf = 0;
    for (int i = 0; i < 13; i++) begin
      press(9);
      novf += int'(digit_ovf);
    end
    tick();
    novf += int'(digit_ovf);
    check("d4_ovf_count", 64'(novf), 1);
    check("d4_a", a, 64'd999999999999);

    // key held through CALC, '=' with empty b
    press(16); press(1); press(10); press(2);
    key_valid = 1'b1;
    key_code = 5'd15;
    tick();
    check("d5_ready_calc", 64'(key_ready), 0);
    check("d5_req", 64'(calc_req), 1);
    key_code = 5'd12;
    tick();
    check("d5_op_kept", 64'(operand), 0);
    check("d5_disp", disp_value, 3);
    tick();
    key_valid = 1'b0;
    check("d5_chain_a", a, 3);
    check("d5_chain_op", 64'(operand), 2);
    press(15);
    check("d5_no_req", 64'(calc_req), 0);

    // reset mid entry
    press(16); press(5); press(10); press(3);
    rst_n = 1'b0;
    #1;
    check("d6_a", a, 0);
    check("d6_b", b, 0);
    check("d6_disp", disp_value, 0);
    check("d6_op", 64'(operand), 0);
    check("d6_pulses", 64'({calc_req, done, digit_ovf}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    press(2); press(10); press(2); press(15);
    tick();
    check("d6_disp4", disp_value, 4);

    // random keys
    for (int n = 0; n < 5000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      key_valid = ($urandom_range(0, 9) < 7);
      rr = $urandom_range(0, 99);
      if (rr < 50) key_code = 5'($urandom_range(0, 9));
      else if (rr < 70) key_code = 5'($urandom_range(10, 14));
      else if (rr < 80) key_code = 5'd15;
      else if (rr < 88) key_code = 5'd17;
      else if (rr < 91) key_code = 5'd16;
      else key_code = 5'($urandom_range(18, 31));
      tick();
    end
    rst_n = 1'b1;
    key_valid = 1'b0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
